rptr_empty_lvl: RTL and testbench

Read-domain pointer and status generator for the asynchronous FIFO, and the parametrised successor of the basic read-pointer/empty block. It contains its own configurable-depth synchronizer for the write-domain Gray pointer. It maintains the binary/Gray read pointers and produces the registered empty flag, a programmable almost-empty flag, a fill-level count and an optional sticky underflow flag. It sits between the read-side consumer, the dual-port memory read address and the write-domain pointer logic.

---
 rtl/rptr_empty_pkg.sv | 42 ++++
 rtl/rptr_empty_lvl_ptr_sync.sv | 39 +++
 rtl/rptr_empty_lvl.sv | 105 ++++++++++
 tb/tb_rptr_empty_lvl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rptr_empty_pkg.sv
// Shared helpers for the read-side FIFO pointer logic: Gray/binary
// conversion and the synchronizer depth limits.
package rptr_empty_pkg;

   localparam int SYNC_STAGES_MIN = 2;
   localparam int SYNC_STAGES_MAX = 4;

   // Widest pointer the conversion helpers handle; callers zero-extend
   // their pointer into this width and pass the real width alongside.
   localparam int PTR_W_MAX = 32;

   // Binary to Gray over the low 'width' bits; bits above 'width' come back zero.
   function automatic logic [PTR_W_MAX-1:0] bin2gray(input logic [PTR_W_MAX-1:0] bin,
                                                     input int                   width);
      logic [PTR_W_MAX-1:0] masked;
      masked = '0;
      for (int i = 0; i < PTR_W_MAX; i++) begin
         if (i < width) begin
            masked[i] = bin[i];
         end
      end
      return (masked >> 1) ^ masked;
   endfunction

   // Gray to binary over the low 'width' bits: each binary bit is the XOR of
   // all Gray bits at and above it within the width.
   function automatic logic [PTR_W_MAX-1:0] gray2bin(input logic [PTR_W_MAX-1:0] gray,
                                                     input int                   width);
      logic [PTR_W_MAX-1:0] bin;
      bin = '0;
      if (width >= PTR_W_MAX) begin
         bin[PTR_W_MAX-1] = gray[PTR_W_MAX-1];
      end
      for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
         if (i < width) begin
            bin[i] = bin[i+1] ^ gray[i];
         end
      end
      return bin;
   endfunction

endpackage

// File: rtl/rptr_empty_lvl_ptr_sync.sv
// ptr_sync: N-flop multi-bit synchronizer for a Gray-coded pointer crossing
// into this clock domain. Only the last stage is meant to be consumed.
module ptr_sync #(
   parameter int WIDTH  = 5,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] sync_d [STAGES];
   logic [WIDTH-1:0] sync_q [STAGES];

   // Each stage takes the previous one; the first stage samples the async input.
   always_comb begin
      sync_d[0] = d;
      for (int i = 1; i < STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   // Shift the chain every edge; reset empties it to a zero pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            sync_q[i] <= sync_d[i];
         end
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/rptr_empty_lvl.sv
// rptr_empty_lvl: read-domain pointer and status for the async FIFO.
// Keeps binary/Gray read pointers, and registers empty, almost-empty and
// fill level from a locally synchronized copy of the write pointer.
// Optional feature macro RPTR_EMPTY_UNDERFLOW_EN adds ruf_clr/runderflow,
// a sticky flag for reads attempted while empty.
module rptr_empty_lvl
   import rptr_empty_pkg::*;
#(
   parameter int ADDRSIZE    = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                rclk,
   input  logic                rrst,
   input  logic [ADDRSIZE:0]   wptr,
   input  logic                rinc,
   input  logic [ADDRSIZE:0]   aempty_thresh,
`ifdef RPTR_EMPTY_UNDERFLOW_EN
   input  logic                ruf_clr,
   output logic                runderflow,
`endif
   output logic [ADDRSIZE-1:0] raddr,
   output logic [ADDRSIZE:0]   rptr,
   output logic                rempty,
   output logic                raempty,
   output logic [ADDRSIZE:0]   rlevel
);

   localparam int PTR_W = ADDRSIZE + 1;

   if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
      $error("rptr_empty_lvl: SYNC_STAGES must be within 2..4");
   end

   logic [ADDRSIZE:0] rq2_wptr;
   logic [ADDRSIZE:0] wbin;
   logic              rd_ok;

   logic [ADDRSIZE:0] rbin_d,    rbin_q;
   logic [ADDRSIZE:0] rptr_d,    rptr_q;
   logic              rempty_d,  rempty_q;
   logic              raempty_d, raempty_q;
   logic [ADDRSIZE:0] rlevel_d,  rlevel_q;
`ifdef RPTR_EMPTY_UNDERFLOW_EN
   logic              ruf_d,     ruf_q;
`endif

   ptr_sync #(
      .WIDTH  (PTR_W),
      .STAGES (SYNC_STAGES)
   ) u_wptr_sync (
      .clk (rclk),
      .rst (rrst),
      .d   (wptr),
      .q   (rq2_wptr)
   );

   // Next pointer, Gray code, level and flags, all derived from the post-read pointer.
   always_comb begin
      rd_ok     = rinc & ~rempty_q;
      rbin_d    = rbin_q + {{ADDRSIZE{1'b0}}, rd_ok};
      rptr_d    = PTR_W'(bin2gray(PTR_W_MAX'(rbin_d), PTR_W));
      wbin      = PTR_W'(gray2bin(PTR_W_MAX'(rq2_wptr), PTR_W));
      rlevel_d  = wbin - rbin_d;
      rempty_d  = (rptr_d == rq2_wptr);
      raempty_d = (rlevel_d <= aempty_thresh);
`ifdef RPTR_EMPTY_UNDERFLOW_EN
      ruf_d     = (rinc & rempty_q) | (ruf_q & ~ruf_clr);
`else
      // Without the underflow flag an ignored read simply leaves no trace.
`endif
   end

   // Register pointers and status; reset returns to an empty FIFO at address 0.
   always_ff @(posedge rclk) begin
      if (rrst) begin
         rbin_q    <= '0;
         rptr_q    <= '0;
         rempty_q  <= 1'b1;
         raempty_q <= 1'b1;
         rlevel_q  <= '0;
`ifdef RPTR_EMPTY_UNDERFLOW_EN
         ruf_q     <= 1'b0;
`endif
      end else begin
         rbin_q    <= rbin_d;
         rptr_q    <= rptr_d;
         rempty_q  <= rempty_d;
         raempty_q <= raempty_d;
         rlevel_q  <= rlevel_d;
`ifdef RPTR_EMPTY_UNDERFLOW_EN
         ruf_q     <= ruf_d;
`endif
      end
   end

   assign raddr   = rbin_q[ADDRSIZE-1:0];
   assign rptr    = rptr_q;
   assign rempty  = rempty_q;
   assign raempty = raempty_q;
   assign rlevel  = rlevel_q;
`ifdef RPTR_EMPTY_UNDERFLOW_EN
   assign runderflow = ruf_q;
`endif

endmodule

// File: tb/tb_rptr_empty_lvl.sv
// Directed self-checking bench for rptr_empty_lvl (ADDRSIZE=4, SYNC_STAGES=2).
// Underflow checks are compiled only when RPTR_EMPTY_UNDERFLOW_EN is defined.
module tb_rptr_empty_lvl;

   logic       rclk;
   logic       rrst;
   logic [4:0] wptr;
   logic       rinc;
   logic [4:0] aempty_thresh;
`ifdef RPTR_EMPTY_UNDERFLOW_EN
   logic       ruf_clr;
   logic       runderflow;
`endif
   logic [3:0] raddr;
   logic [4:0] rptr;
   logic       rempty;
   logic       raempty;
   logic [4:0] rlevel;

   int num_checks;
   int num_failures;

   rptr_empty_lvl #(
      .ADDRSIZE    (4),
      .SYNC_STAGES (2)
   ) dut (
      .rclk          (rclk),
      .rrst          (rrst),
      .wptr          (wptr),
      .rinc          (rinc),
      .aempty_thresh (aempty_thresh),
`ifdef RPTR_EMPTY_UNDERFLOW_EN
      .ruf_clr       (ruf_clr),
      .runderflow    (runderflow),
`endif
      .raddr         (raddr),
      .rptr          (rptr),
      .rempty        (rempty),
      .raempty       (raempty),
      .rlevel        (rlevel)
   );

   // Free-running read clock, 10 ns period.
   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   // Drive reset/read request, then advance one edge and settle 1 ns past it.
   task automatic applyStimulus(input logic rst, input logic inc);
      rrst = rst;
      rinc = inc;
      @(posedge rclk);
      #1;
   endtask

   // Count one comparison and report it if observed differs from expected.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      num_checks++;
      if (observed !== expected) begin
         num_failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Three idle edges let a new wptr cross the 2-stage sync and reach the flags.
   task automatic settle();
      for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0);
   endtask

   int exp_drain_addr  [4] = '{1, 2, 3, 3};
   int exp_drain_level [4] = '{2, 1, 0, 0};
   int exp_drain_empty [4] = '{0, 0, 1, 1};
   int exp_wrap_addr   [4] = '{15, 0, 1, 2};
   int exp_wrap_level  [4] = '{3, 2, 1, 0};

   initial begin
      num_checks    = 0;
      num_failures  = 0;
      rrst          = 1'b1;
      rinc          = 1'b0;
      wptr          = 5'b00010;
      aempty_thresh = 5'd4;
`ifdef RPTR_EMPTY_UNDERFLOW_EN
      ruf_clr       = 1'b0;
`endif

      // Reset with a nonzero wptr present.
      applyStimulus(1'b1, 1'b0);
      checkOutput("rst_rempty",  32'(rempty),  1);
      checkOutput("rst_raempty", 32'(raempty), 1);
      checkOutput("rst_rlevel",  32'(rlevel),  0);
      checkOutput("rst_raddr",   32'(raddr),   0);
      checkOutput("rst_rptr",    32'(rptr),    0);
`ifdef RPTR_EMPTY_UNDERFLOW_EN
      checkOutput("rst_ruf",     32'(runderflow), 0);
`endif

      // Write visibility: wptr 0 -> gray 00010 (binary 3).
      wptr = 5'b00000;
      settle();
      wptr = 5'b00010;
      applyStimulus(1'b0, 1'b0);
      checkOutput("vis1_rempty", 32'(rempty), 1);
      checkOutput("vis1_rlevel", 32'(rlevel), 0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("vis2_rempty", 32'(rempty), 1);
      checkOutput("vis2_rlevel", 32'(rlevel), 0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("vis3_rempty",  32'(rempty),  0);
      checkOutput("vis3_rlevel",  32'(rlevel),  3);
      checkOutput("vis3_raempty", 32'(raempty), 1);
      aempty_thresh = 5'd2;
      applyStimulus(1'b0, 1'b0);
      checkOutput("thr2_raempty", 32'(raempty), 0);
      checkOutput("thr2_rlevel",  32'(rlevel),  3);

      // Drain from level 3 with rinc held for 4 edges; the last is a read while empty.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b1);
         checkOutput("drain_raddr",  32'(raddr),  32'(exp_drain_addr[i]));
         checkOutput("drain_rlevel", 32'(rlevel), 32'(exp_drain_level[i]));
         checkOutput("drain_rempty", 32'(rempty), 32'(exp_drain_empty[i]));
      end
`ifdef RPTR_EMPTY_UNDERFLOW_EN
      checkOutput("uf_set", 32'(runderflow), 1);
      applyStimulus(1'b0, 1'b0);
      checkOutput("uf_sticky", 32'(runderflow), 1);
      ruf_clr = 1'b1;
      applyStimulus(1'b0, 1'b0);
      checkOutput("uf_clr", 32'(runderflow), 0);
      applyStimulus(1'b0, 1'b1);
      checkOutput("uf_set_wins", 32'(runderflow), 1);
      checkOutput("uf_raddr_hold", 32'(raddr), 3);
      applyStimulus(1'b0, 1'b0);
      checkOutput("uf_clr2", 32'(runderflow), 0);
      ruf_clr = 1'b0;
`endif

      // Wrap-around: advance rbin 3 -> 18 -> 30, then write up to binary 2.
      wptr = 5'b11011;
      settle();
      checkOutput("pre18_rlevel", 32'(rlevel), 15);
      for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b1);
      checkOutput("pre18_raddr",  32'(raddr),  2);
      checkOutput("pre18_rempty", 32'(rempty), 1);
      wptr = 5'b10001;
      settle();
      checkOutput("pre30_rlevel", 32'(rlevel), 12);
      for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1);
      checkOutput("pre30_raddr",  32'(raddr),  14);
      checkOutput("pre30_rempty", 32'(rempty), 1);
      wptr = 5'b00011;
      settle();
      checkOutput("wrap_rlevel0", 32'(rlevel), 4);
      checkOutput("wrap_rempty0", 32'(rempty), 0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b1);
         checkOutput("wrap_raddr",  32'(raddr),  32'(exp_wrap_addr[i]));
         checkOutput("wrap_rlevel", 32'(rlevel), 32'(exp_wrap_level[i]));
      end
      checkOutput("wrap_rptr",   32'(rptr),   5'b00011);
      checkOutput("wrap_rempty", 32'(rempty), 1);

      // Threshold boundary at 5: level 5 is almost-empty, level 6 is not.
      applyStimulus(1'b0, 1'b0);
      aempty_thresh = 5'd5;
      wptr = 5'b00100;
      settle();
      checkOutput("thr5_lvl5",     32'(rlevel),  5);
      checkOutput("thr5_raempty1", 32'(raempty), 1);
      wptr = 5'b01100;
      settle();
      checkOutput("thr5_lvl6",     32'(rlevel),  6);
      checkOutput("thr5_raempty0", 32'(raempty), 0);

      // Threshold 0: raempty follows rempty while draining 6 words.
      aempty_thresh = 5'd0;
      applyStimulus(1'b0, 1'b0);
      checkOutput("thr0_raempty", 32'(raempty), 0);
      checkOutput("thr0_rempty",  32'(rempty),  0);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 1'b1);
         checkOutput("thr0_rlevel",   32'(rlevel),  32'(5 - i));
         checkOutput("thr0_rempty_i", 32'(rempty),  (i == 5) ? 1 : 0);
         checkOutput("thr0_raempty_i", 32'(raempty), (i == 5) ? 1 : 0);
      end

      // Full FIFO (level 16) with threshold 16 keeps raempty high.
      aempty_thresh = 5'd16;
      wptr = 5'b10100;
      settle();
      checkOutput("thr16_rlevel",  32'(rlevel),  16);
      checkOutput("thr16_rempty",  32'(rempty),  0);
      checkOutput("thr16_raempty", 32'(raempty), 1);

      // Reset mid-operation: reach rbin=3 with wptr at binary 8, then reset.
      aempty_thresh = 5'd4;
      wptr = 5'b01100;
      applyStimulus(1'b1, 1'b0);
      settle();
      checkOutput("mid_pre_rlevel", 32'(rlevel), 8);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
      checkOutput("mid_lvl5",  32'(rlevel), 5);
      checkOutput("mid_raddr", 32'(raddr),  3);
      applyStimulus(1'b1, 1'b1);
      checkOutput("mid_rst_rempty", 32'(rempty), 1);
      checkOutput("mid_rst_rlevel", 32'(rlevel), 0);
      checkOutput("mid_rst_raddr",  32'(raddr),  0);
      checkOutput("mid_rst_rptr",   32'(rptr),   0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("mid_e1_rempty", 32'(rempty), 1);
      checkOutput("mid_e1_rlevel", 32'(rlevel), 0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("mid_e2_rempty", 32'(rempty), 1);
      checkOutput("mid_e2_rlevel", 32'(rlevel), 0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("mid_e3_rempty", 32'(rempty), 0);
      checkOutput("mid_e3_rlevel", 32'(rlevel), 8);

      $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_failures);
      $finish;
   end

endmodule
